// File: rtl/gnrc_pkg.sv
// gnrc_pkg: shared helpers for the generic arbiter family.
//   RR_MAX_N : widest requester vector rr_pick accepts
//   RR_PTR_W : width of the rr_pick priority pointer
//   rr_pick  : round-robin one-hot winner selection
package gnrc_pkg;

   localparam int unsigned RR_MAX_N = 32;
   localparam int unsigned RR_PTR_W = $clog2(RR_MAX_N);

   // Returns the first set bit of req at or after ptr, wrapping, as a one-hot
   // vector. Callers zero-extend narrower vectors: the unused upper bits are
   // zero, so wrapping at RR_MAX_N gives the same winner as wrapping at N.
   function automatic logic [RR_MAX_N-1:0] rr_pick(input logic [RR_MAX_N-1:0] req,
                                                   input logic [RR_PTR_W-1:0] ptr);
      logic [2*RR_MAX_N-1:0] dbl;
      logic [2*RR_MAX_N-1:0] first;
      // Upper copy covers the requesters below ptr after the wrap.
      dbl   = {req, req} & ({(2*RR_MAX_N){1'b1}} << ptr);
      // Isolate the lowest set bit.
      first = dbl & (~dbl + (2*RR_MAX_N)'(1));
      return first[RR_MAX_N-1:0] | first[2*RR_MAX_N-1:RR_MAX_N];
   endfunction

endpackage

// File: rtl/gnrc_onehot2bin.sv
// gnrc_onehot2bin: one-hot (or all-zero) vector to binary index.
//   N        : vector width
//   M        : index width, derived
//   onehot_i : one-hot0 input
//   bin_o    : index of the set bit, 0 when no bit is set
module gnrc_onehot2bin #(
   parameter int unsigned N = 4,
   parameter int unsigned M = $clog2(N) + ((N == 1) ? 1 : 0)
) (
   input  logic [N-1:0] onehot_i,
   output logic [M-1:0] bin_o
);

   // OR of the indices of all set bits; exact when the input is one-hot0.
   always_comb begin
      bin_o = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (onehot_i[k]) begin
            bin_o = bin_o | M'(k);
         end
      end
   end

`ifndef SYNTHESIS
   always_comb begin
      assert ($onehot0(onehot_i));
   end
`endif

endmodule

// File: rtl/gnrc_rr_arbiter.sv
// gnrc_rr_arbiter: round-robin N:1 valid/ready merge with a one-entry
// registered output stage.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   req_valid_i/_data_i   : per-requester valid and payload
//   req_ready_o           : one-hot0 grant to the requester being loaded
//   out_valid_o/_data_o   : held beat and its payload
//   out_grant_o/_idx_o    : one-hot and binary source of the held beat
//   out_ready_i           : downstream ready
module gnrc_rr_arbiter
   import gnrc_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned DW = 32,
   parameter int unsigned M  = $clog2(N) + ((N == 1) ? 1 : 0)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N-1:0]         req_valid_i,
   input  logic [N-1:0][DW-1:0] req_data_i,
   output logic [N-1:0]         req_ready_o,
   output logic                 out_valid_o,
   output logic [DW-1:0]        out_data_o,
   output logic [N-1:0]         out_grant_o,
   output logic [M-1:0]         out_idx_o,
   input  logic                 out_ready_i
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   if (N > RR_MAX_N) begin : g_n_check
      $error("gnrc_rr_arbiter: N exceeds gnrc_pkg::RR_MAX_N");
   end

   state_t         state_q, state_d;
   logic [DW-1:0]  data_q,  data_d;
   logic [N-1:0]   grant_q, grant_d;
   logic [M-1:0]   idx_q,   idx_d;
   logic [M-1:0]   ptr_q,   ptr_d;

   logic           load_en;
   logic [N-1:0]   win;
   logic [M-1:0]   win_idx;
   logic [M-1:0]   win_next;
   logic [DW-1:0]  data_mux;

   // Stage can accept a beat when empty or when the held beat leaves now.
   assign load_en = (state_q == EMPTY) | out_ready_i;

   assign win = N'(rr_pick(RR_MAX_N'(req_valid_i), RR_PTR_W'(ptr_q)));

   gnrc_onehot2bin #(.N(N)) u_onehot2bin (
      .onehot_i (win),
      .bin_o    (win_idx)
   );

   // Pointer moves one past the winner, wrapping at N-1.
   assign win_next = (win_idx == M'(N - 1)) ? '0 : win_idx + M'(1);

   // AND-OR payload select on the one-hot winner.
   always_comb begin
      data_mux = '0;
      for (int unsigned k = 0; k < N; k++) begin
         data_mux = data_mux | (req_data_i[k] & {DW{win[k]}});
      end
   end

   assign req_ready_o = (load_en && !rst_i) ? win : '0;

   // Output stage and pointer next state.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      if (load_en) begin
         if (|win) begin
            state_d = FULL;
            data_d  = data_mux;
            grant_d = win;
            idx_d   = win_idx;
            ptr_d   = win_next;
         end else begin
            state_d = EMPTY;
            grant_d = '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= EMPTY;
         data_q  <= '0;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_valid_o = (state_q == FULL);
   assign out_data_o  = data_q;
   assign out_grant_o = grant_q;
   assign out_idx_o   = idx_q;

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      assert ($onehot0(req_ready_o));
      assert ($onehot0(out_grant_o));
   end
`endif

endmodule

// File: tb/tb_gnrc_rr_arbiter.sv
// tb_gnrc_rr_arbiter: scenario tasks plus a randomized run, all checked
// against a transaction-level round-robin model kept in the bench.
module tb_gnrc_rr_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned M  = 2;
   localparam int unsigned OW = 1 + DW + N + M;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0]         req_valid;
   logic [N-1:0][DW-1:0] req_data;
   logic [N-1:0]         req_ready;
   logic                 out_valid;
   logic [DW-1:0]        out_data;
   logic [N-1:0]         out_grant;
   logic [M-1:0]         out_idx;
   logic                 out_ready;

   int vectors  = 0;
   int mismatch = 0;

   // Reference model state.
   logic          m_valid = 1'b0;
   logic [DW-1:0] m_data  = '0;
   logic [N-1:0]  m_grant = '0;
   int            m_idx   = 0;
   int            m_ptr   = 0;

   gnrc_rr_arbiter #(.N(N), .DW(DW)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_ready_o (req_ready),
      .out_valid_o (out_valid),
      .out_data_o  (out_data),
      .out_grant_o (out_grant),
      .out_idx_o   (out_idx),
      .out_ready_i (out_ready)
   );

   always #5 clk = ~clk;

   // First valid requester scanning from the pointer, -1 if none.
   function automatic int m_winner();
      for (int j = 0; j < N; j++) begin
         if (req_valid[(m_ptr + j) % N]) return (m_ptr + j) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] m_ready();
      int w;
      w = m_winner();
      if (rst || (m_valid && !out_ready) || w < 0) return '0;
      return N'(1) << w;
   endfunction

   function automatic logic [OW-1:0] m_out();
      return {m_valid, m_data, m_grant, M'(m_idx)};
   endfunction

   function automatic logic [OW-1:0] dut_out();
      return {out_valid, out_data, out_grant, out_idx};
   endfunction

   // Advance one clock, updating the model from the inputs present at the edge.
   task automatic tick();
      int   w;
      logic load;
      @(posedge clk);
      w    = m_winner();
      load = !m_valid || out_ready;
      if (rst) begin
         m_valid = 1'b0; m_data = '0; m_grant = '0; m_idx = 0; m_ptr = 0;
      end else if (load) begin
         if (w >= 0) begin
            m_valid = 1'b1;
            m_data  = req_data[w];
            m_grant = N'(1) << w;
            m_idx   = w;
            m_ptr   = (w + 1) % N;
         end else begin
            m_valid = 1'b0;
            m_grant = '0;
         end
      end
      @(negedge clk);
   endtask

   task automatic set_default_data();
      for (int k = 0; k < N; k++) req_data[k] = DW'(32'hA0 + k);
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '1; out_ready = 1'b1; set_default_data();
      for (int c = 0; c < 2; c++) begin
         #1;
         vectors++;
         if (req_ready !== '0) begin
            mismatch++; $display("FAIL reset_ready: got %b want 0", req_ready);
         end
         tick();
         vectors++;
         if (dut_out() !== '0) begin
            mismatch++; $display("FAIL reset_outputs: got %h want 0", dut_out());
         end
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (req_ready !== 4'b0001) begin
         mismatch++; $display("FAIL reset_first_ready: got %b want 0001", req_ready);
      end
      tick();
      vectors++;
      if (dut_out() !== {1'b1, 32'hA0, 4'b0001, 2'd0}) begin
         mismatch++; $display("FAIL reset_first_grant: got %h want %h", dut_out(), {1'b1, 32'hA0, 4'b0001, 2'd0});
      end
   endtask

   task automatic test_rotation();
      rst = 1'b1; tick(); rst = 1'b0;
      req_valid = 4'b1111; out_ready = 1'b1; set_default_data();
      for (int i = 0; i < 6; i++) begin
         #1;
         vectors++;
         if (req_ready !== m_ready()) begin
            mismatch++; $display("FAIL rot_ready: got %b want %b", req_ready, m_ready());
         end
         tick();
         vectors++;
         if ({out_valid, out_idx, out_data} !== {1'b1, M'(i % N), DW'(32'hA0 + i % N)}) begin
            mismatch++;
            $display("FAIL rot_beat%0d: got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h",
                     i, out_valid, out_idx, out_data, i % N, 32'hA0 + i % N);
         end
      end
   endtask

   task automatic test_skip_idle();
      rst = 1'b1; tick(); rst = 1'b0;
      out_ready = 1'b1; set_default_data();
      req_valid = 4'b0001; tick();
      req_valid = 4'b1001; tick();
      vectors++;
      if ({out_grant, out_idx} !== {4'b1000, 2'd3}) begin
         mismatch++; $display("FAIL skip_grant3: got grant=%b idx=%0d want 1000/3", out_grant, out_idx);
      end
      #1;
      vectors++;
      if (req_ready !== 4'b0001) begin
         mismatch++; $display("FAIL skip_wrap_ready: got %b want 0001", req_ready);
      end
      tick();
      vectors++;
      if ({out_grant, out_idx, out_data} !== {4'b0001, 2'd0, 32'hA0}) begin
         mismatch++; $display("FAIL skip_grant0: got grant=%b idx=%0d data=%h", out_grant, out_idx, out_data);
      end
   endtask

   task automatic test_backpressure();
      logic [OW-1:0] held;
      req_valid = 4'b1111; out_ready = 1'b1; set_default_data();
      tick();
      held = m_out();
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         for (int k = 0; k < N; k++) req_data[k] = $urandom;
         #1;
         vectors++;
         if (req_ready !== '0) begin
            mismatch++; $display("FAIL bp_ready: got %b want 0", req_ready);
         end
         tick();
         vectors++;
         if (dut_out() !== held) begin
            mismatch++; $display("FAIL bp_stable: got %h want %h", dut_out(), held);
         end
      end
      out_ready = 1'b1;
      #1;
      vectors++;
      if (req_ready !== m_ready() || req_ready === '0) begin
         mismatch++; $display("FAIL bp_release_ready: got %b want %b", req_ready, m_ready());
      end
      tick();
      vectors++;
      if (dut_out() !== m_out() || !out_valid) begin
         mismatch++; $display("FAIL bp_release_load: got %h want %h", dut_out(), m_out());
      end
   endtask

   task automatic test_drain();
      rst = 1'b1; tick(); rst = 1'b0;
      out_ready = 1'b1; set_default_data();
      req_valid = 4'b0100; tick();
      vectors++;
      if (dut_out() !== {1'b1, 32'hA2, 4'b0100, 2'd2}) begin
         mismatch++; $display("FAIL drain_load: got %h want %h", dut_out(), {1'b1, 32'hA2, 4'b0100, 2'd2});
      end
      req_valid = 4'b0000; tick();
      vectors++;
      if (dut_out() !== {1'b0, 32'hA2, 4'b0000, 2'd2}) begin
         mismatch++; $display("FAIL drain_empty: got %h want %h", dut_out(), {1'b0, 32'hA2, 4'b0000, 2'd2});
      end
      req_valid = 4'b1111;
      #1;
      vectors++;
      if (req_ready !== 4'b1000) begin
         mismatch++; $display("FAIL drain_ptr_kept: got %b want 1000", req_ready);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1; req_valid = 4'b0110; set_default_data();
      tick();
      out_ready = 1'b0; tick();
      rst = 1'b1;
      #1;
      vectors++;
      if (req_ready !== '0) begin
         mismatch++; $display("FAIL rstmid_ready: got %b want 0", req_ready);
      end
      tick();
      vectors++;
      if (dut_out() !== '0) begin
         mismatch++; $display("FAIL rstmid_outputs: got %h want 0", dut_out());
      end
      rst = 1'b0; req_valid = 4'b1111; out_ready = 1'b1;
      tick();
      vectors++;
      if ({out_valid, out_grant, out_idx} !== {1'b1, 4'b0001, 2'd0}) begin
         mismatch++; $display("FAIL rstmid_restart: got v=%b grant=%b idx=%0d", out_valid, out_grant, out_idx);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst       = ($urandom_range(0, 59) == 0);
         req_valid = N'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < N; k++) req_data[k] = $urandom;
         #1;
         vectors++;
         if (req_ready !== m_ready()) begin
            mismatch++; $display("FAIL rand_ready@%0d: got %b want %b", c, req_ready, m_ready());
         end
         tick();
         vectors++;
         if (dut_out() !== m_out()) begin
            mismatch++; $display("FAIL rand_out@%0d: got %h want %h", c, dut_out(), m_out());
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; out_ready = 1'b0; set_default_data();
      @(negedge clk);
      test_reset();
      test_rotation();
      test_skip_idle();
      test_backpressure();
      test_drain();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, mismatch);
      $finish;
   end

endmodule
